bcd_seq_conv: RTL

- Parametrised, iterative (shift-and-add-3 / double-dabble) binary-to-BCD converter with a start/done handshake.
- Successor to the combinational 8-bit ones/tens/hundreds converter. Generalised to WIDTH-bit input and DIGITS BCD digits.
- Adds a signed (two's-complement) mode with sign output and an overflow flag when DIGITS is too small.
- Sits between datapath results (e.g. multiplier products) and display/BCD consumers.

---
 rtl/bcd_seq_conv.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv
//   Iterative binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It generalises the older combinational 8-bit ones/tens/hundreds converter
//   to WIDTH input bits and DIGITS output digits. It also adds a two's-complement
//   mode with a sign output, and an overflow flag for when DIGITS is too few.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   conversion request, sampled only while idle
//   sign_mode  in   1 = bin is two's complement, 0 = unsigned (sampled with start)
//   bin        in   WIDTH-bit operand (sampled with start)
//   busy       out  conversion in progress
//   done       out  one-cycle pulse, results valid
//   bcd        out  packed BCD, digit k at [4k+3:4k], digit 0 = ones
//   neg        out  result is negative (signed mode only)
//   overflow   out  magnitude needed more than DIGITS digits
//
// Timing: the start edge loads the operand. The next WIDTH edges each run one
// iteration. The last iteration also registers bcd/neg/overflow and pulses done.
// A start that is held high is therefore re-accepted on the edge where done is
// high. This gives one conversion every WIDTH+1 clocks.

module bcd_seq_conv #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sign_mode,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mag;
  logic [SW-1:0]      r_scr;
  logic               r_sign;
  logic               r_ovf_acc;

  logic [SW-1:0]      r_bcd;
  logic               r_neg;
  logic               r_ovf;
  logic               r_done;

  logic               w_load_neg;
  logic [WIDTH-1:0]   w_load_mag;
  logic [SW-1:0]      w_adj;
  logic [SW-1:0]      w_scr_nxt;
  logic [WIDTH-1:0]   w_mag_nxt;
  logic               w_out_bit;
  logic               w_last;

  // Operand conditioning. For the most negative value, negation wraps back to
  // the same bit pattern. Read as unsigned, that pattern is the correct
  // magnitude 2^(WIDTH-1).
  always_comb begin
    w_load_neg = sign_mode & bin[WIDTH-1];
    w_load_mag = w_load_neg ? (~bin + WIDTH'(1)) : bin;
  end

  // One double-dabble iteration. First adjust every digit that is >= 5.
  // Then shift {scratch, magnitude} left by one bit. The bit that leaves the
  // top digit is lost from the result, but it is recorded as overflow.
  always_comb begin
    w_adj = r_scr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
    end
    {w_out_bit, w_scr_nxt, w_mag_nxt} = {w_adj, r_mag, 1'b0};
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_IDLE;
      default:              w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mag     <= '0;
      r_scr     <= '0;
      r_sign    <= 1'b0;
      r_ovf_acc <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mag     <= w_load_mag;
            r_sign    <= w_load_neg;
            r_scr     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_scr     <= w_scr_nxt;
          r_mag     <= w_mag_nxt;
          r_cnt     <= r_cnt + CW'(1);
          r_ovf_acc <= r_ovf_acc | w_out_bit;
          if (w_last) begin
            r_bcd  <= w_scr_nxt;
            r_ovf  <= r_ovf_acc | w_out_bit;
            // The sign is set only when the top bit is set in signed mode.
            // The magnitude is never zero in that case, so neg stays 0 for a
            // zero result.
            r_neg  <= r_sign;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == ST_SHIFT);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign neg      = r_neg;
  assign overflow = r_ovf;

endmodule
